// File: rtl/conv_window_5x5.sv
// conv_window_5x5: 5x5 sliding window over a row-buffer chain.
// The live pixel (tap0) and four delayed rows (tap1..tap4) form one vertical
// column that is shifted into the right edge of a 5x5 register window on
// every accepted pixel. Frame position counters track the pixel on tap0.
// valid marks a complete 5x5 neighbourhood that does not straddle two rows.
// Optional feature macro: CONV_WINDOW_FRAME_DONE_EN enables the end-of-frame
// pulse on frame_done; without it the port is tied to 0.
// Handshake: en is a one-way strobe with no ready. Each en edge accepts one
// pixel, and valid pulses for exactly one cycle after each accepted pixel that
// completes a window. The consumer must take every valid pulse.
module conv_window_5x5 #(
  parameter int LENGTH    = 32,
  parameter int HEIGHT    = 32,
  parameter int BIT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [BIT_WIDTH-1:0]        tap0,
  input  logic [BIT_WIDTH-1:0]        tap1,
  input  logic [BIT_WIDTH-1:0]        tap2,
  input  logic [BIT_WIDTH-1:0]        tap3,
  input  logic [BIT_WIDTH-1:0]        tap4,
  output logic [25*BIT_WIDTH-1:0]     window,
  output logic                        valid,
  output logic [$clog2(HEIGHT)-1:0]   win_row,
  output logic [$clog2(LENGTH)-1:0]   win_col,
  output logic                        frame_done
);

  localparam int CW = $clog2(LENGTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(LENGTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_FOUR = CW'(4);
  localparam logic [RW-1:0] ROW_FOUR = RW'(4);

  logic [BIT_WIDTH-1:0] r_win [5][5];
  logic [CW-1:0]        r_col_cnt;
  logic [RW-1:0]        r_row_cnt;
  logic                 r_valid;
  logic [RW-1:0]        r_win_row;
  logic [CW-1:0]        r_win_col;

  logic [BIT_WIDTH-1:0] w_new_col [5];
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_full;

  // Incoming column: row 0 of the window is the oldest row (tap4).
  always_comb begin
    w_new_col[0] = tap4;
    w_new_col[1] = tap3;
    w_new_col[2] = tap2;
    w_new_col[3] = tap1;
    w_new_col[4] = tap0;
  end

  assign w_col_last = (r_col_cnt == COL_LAST);
  assign w_row_last = (r_row_cnt == ROW_LAST);
  // Columns 0..3 of a row would pull in the previous row's tail, so they never
  // complete a window; rows 0..3 would pull in stale row-buffer contents.
  assign w_full     = (r_row_cnt >= ROW_FOUR) && (r_col_cnt >= COL_FOUR);

  // Window shift register: older columns move left, new column enters at c=4.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (en) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          r_win[r][c] <= r_win[r][c+1];
        end
        r_win[r][4] <= w_new_col[r];
      end
    end
  end

  // Frame position of the pixel currently presented on tap0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (en) begin
      if (w_col_last) begin
        r_col_cnt <= '0;
        r_row_cnt <= w_row_last ? '0 : r_row_cnt + RW'(1);
      end else begin
        r_col_cnt <= r_col_cnt + CW'(1);
      end
    end
  end

  // Valid pulse and top-left coordinate of the window it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_win_row <= '0;
      r_win_col <= '0;
    end else begin
      r_valid <= en && w_full;
      if (en && w_full) begin
        r_win_row <= r_row_cnt - ROW_FOUR;
        r_win_col <= r_col_cnt - COL_FOUR;
      end
    end
  end

`ifdef CONV_WINDOW_FRAME_DONE_EN
  logic r_frame_done;

  // One-cycle pulse alongside the valid of the frame's last pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= en && w_col_last && w_row_last;
    end
  end

  assign frame_done = r_frame_done;
`else
  assign frame_done = 1'b0;
`endif

  for (genvar gr = 0; gr < 5; gr++) begin : g_row
    for (genvar gc = 0; gc < 5; gc++) begin : g_col
      assign window[(gr*5+gc)*BIT_WIDTH +: BIT_WIDTH] = r_win[gr][gc];
    end
  end

  assign valid   = r_valid;
  assign win_row = r_win_row;
  assign win_col = r_win_col;

endmodule

// File: doc/conv_window_5x5.md
# conv_window_5x5

Sliding-window reader for the 4-deep row-buffer chain. It takes the live pixel plus the four delayed row taps as five vertically aligned pixels, and shifts them into a 5x5 register window. It tracks frame position and flags each clock in which the window holds a complete, non-wrapping 5x5 neighbourhood. It sits between the row-buffer chain and the convolution MAC array, and shares the chain's pixel-enable strobe.

## Interface
- LENGTH, 32, pixels per image row; must equal the row-buffer LENGTH; minimum 5.
- HEIGHT, 32, rows per frame; minimum 5.
- BIT_WIDTH, 8, pixel width.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  pixel strobe; the same signal that drives the row-buffer enable.
- tap0  in  BIT_WIDTH  newest row: the live pixel fed into the chain.
- tap1..tap4  in  BIT_WIDTH each  row-buffer outputs out0..out3; tap4 is the oldest row.
- window  out  25*BIT_WIDTH  element (r,c) at [(r*5+c)*BIT_WIDTH +: BIT_WIDTH]; r=0 is the oldest row, c=0 is the oldest column.
- valid  out  1  window holds a complete 5x5 neighbourhood.
- win_row  out  $clog2(HEIGHT)  top-left row of the current window.
- win_col  out  $clog2(LENGTH)  top-left column of the current window.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame.

## Operation
- Internal counters:
  - col_cnt runs 0..LENGTH-1.
  - row_cnt runs 0..HEIGHT-1.
  - Both give the position of the pixel currently presented on tap0.
- On a clock with en=1:
  - Shift: window(r,c) <= window(r,c+1) for c=0..3.
  - Load column 4: window(r,4) <= tap(4-r), so row 0 takes tap4 and row 4 takes tap0.
  - valid <= (row_cnt>=4 && col_cnt>=4).
  - win_row <= row_cnt-4 and win_col <= col_cnt-4, updated only when the new valid is 1.
  - Advance col_cnt. On LENGTH-1 it wraps to 0 and row_cnt advances. On (HEIGHT-1, LENGTH-1) both counters wrap to 0.
- On a clock with en=0:
  - window, counters, win_row and win_col hold.
  - valid <= 0.
- valid is a one-cycle pulse per accepted pixel. It is never held high across an en=0 cycle.
- Row wrap: at col_cnt 0..3 the window columns straddle two image rows, so valid is 0.
- Stale row-buffer contents after reset are harmless: rows 0..3 of every frame never produce valid.
- No backpressure: the downstream consumer must accept every valid pulse.
- Reset (rst_n=0 at an edge), including mid-frame:
  - All window elements, counters, valid, win_row, win_col and frame_done go to 0.
  - The first en pixel after release is position (0,0).

## Timing
- Latency is one clock: the pixel on tap0 at en edge k appears in window(4,4), and its valid is high, in the cycle after edge k.
- Maximum throughput is one pixel per clock, with en held high continuously.
- Valid windows per frame: exactly (HEIGHT-4)*(LENGTH-4).
- The reset value of every output is 0.

## Configuration
- Macro: CONV_WINDOW_FRAME_DONE_EN.
- Defined:
  - frame_done <= 1 on the en edge that accepts pixel (HEIGHT-1, LENGTH-1), coincident with that pixel's valid.
  - frame_done <= 0 on every other edge.
- Undefined: the port remains present and is tied to 0, and no end-of-frame detection logic is built.

## Test plan
- Reset: rst_n low for 2 clocks with random taps and en=1 -> valid=0, frame_done=0, window all 0, win_row=win_col=0.
- Full frame, BIT_WIDTH=16, pixel value r*32+c, en continuously high:
  - exactly 784 valid pulses;
  - the first at pixel (4,4), with window(0,0)=0, window(4,4)=132, win_row=0, win_col=0;
  - the last with window(4,4)=1023.
- Same frame with en high only 1 clock in 3 -> identical 784 window contents, in the same order; valid is never high for two consecutive clocks.
- Row wrap:
  - pixels (5,0)..(5,3) -> valid=0;
  - pixel (5,4) -> valid=1, win_row=1, win_col=0, window(4,0)=160.
- Reset after pixel (10,10), then the frame is restarted -> no valid until the new frame's pixel (4,4), and its window equals the window seen at (4,4) in the full-frame test.
- frame_done:
  - with CONV_WINDOW_FRAME_DONE_EN defined -> a single 1-cycle pulse, coincident with the valid for pixel (31,31), then 0;
  - undefined -> frame_done stays 0 throughout.
